// File: rtl/bp_hb_mem_rev_assembler.sv
// Collects 32b manycore load returns, indexed by load-id, into one wide BedRock mem_rev response.
// Optional macro BP_HB_REV_TIMEOUT_EN: bounds COLLECT to timeout_p cycles, then zero-fills missing words.
module bp_hb_mem_rev_assembler #(
  parameter int header_width_p = 64,
  parameter int max_words_p = 16,
  parameter int timeout_p = 1024,
  localparam int lg_max_words_lp = $clog2(max_words_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [header_width_p-1:0]   fwd_header_i,
  input  logic [lg_max_words_lp:0]    fwd_words_i,
  input  logic                        fwd_v_i,
  output logic                        fwd_ready_and_o,
  input  logic [31:0]                 ret_data_i,
  input  logic [lg_max_words_lp-1:0]  ret_idx_i,
  input  logic                        ret_v_i,
  output logic                        ret_ready_and_o,
  output logic [header_width_p-1:0]   mem_rev_header_o,
  output logic [32*max_words_p-1:0]   mem_rev_data_o,
  output logic                        mem_rev_v_o,
  input  logic                        mem_rev_ready_and_i,
  output logic                        err_o
);

  localparam logic [1:0] state_idle    = 2'd0;
  localparam logic [1:0] state_collect = 2'd1;
  localparam logic [1:0] state_send    = 2'd2;
  localparam logic [lg_max_words_lp:0] max_count_lp = (lg_max_words_lp+1)'(max_words_p);

  logic [1:0]                 state_reg, state_next;
  logic [header_width_p-1:0]  header_reg;
  logic [lg_max_words_lp:0]   count_reg;
  logic [lg_max_words_lp:0]   filled_reg;
  logic [max_words_p-1:0]     mask_reg;
  logic                       err_reg;

  logic fwd_fire, ret_fire, idx_ok, idx_new, ret_write, ret_bad;
  logic words_bad, complete, timeout_hit;

  // Handshake readies are decoded from state alone, never from the valids.
  assign fwd_ready_and_o = (state_reg == state_idle);
  assign ret_ready_and_o = (state_reg == state_collect);
  assign mem_rev_v_o     = (state_reg == state_send);

  assign fwd_fire  = fwd_v_i & fwd_ready_and_o;
  assign ret_fire  = ret_v_i & ret_ready_and_o;
  assign idx_ok    = ({1'b0, ret_idx_i} < count_reg);
  assign idx_new   = idx_ok & ~mask_reg[ret_idx_i];
  assign ret_write = ret_fire & idx_new;
  assign ret_bad   = ret_fire & ~idx_new;
  assign words_bad = (fwd_words_i == '0) || (fwd_words_i > max_count_lp);
  // filled_reg mirrors popcount(mask_reg) since only fresh indices are ever written.
  assign complete  = ret_write & ((filled_reg + 1'b1) == count_reg);

`ifdef BP_HB_REV_TIMEOUT_EN
  localparam int timer_width_lp = $clog2(timeout_p + 1);
  localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);
  logic [timer_width_lp-1:0] timer_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i || fwd_fire) begin
      timer_reg <= '0;
    end else if (state_reg == state_collect) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  assign timeout_hit = (state_reg == state_collect) && (timer_reg == timer_last_lp) && !complete;
`else
  // timeout_p has no effect without the timeout option.
  assign timeout_hit = 1'b0 && (timeout_p != 0);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      state_idle:    if (fwd_fire) state_next = state_collect;
      state_collect: if (complete || timeout_hit) state_next = state_send;
      state_send:    if (mem_rev_ready_and_i) state_next = state_idle;
      default:       state_next = state_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg  <= state_idle;
      header_reg <= '0;
      count_reg  <= '0;
      filled_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (fwd_fire) begin
        header_reg <= fwd_header_i;
        count_reg  <= words_bad ? max_count_lp : fwd_words_i;
        filled_reg <= '0;
      end else if (ret_write) begin
        filled_reg <= filled_reg + 1'b1;
      end
      if ((fwd_fire && words_bad) || ret_bad || timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Per-word storage; words never written stay zero from the clear at header capture.
  for (genvar gi = 0; gi < max_words_p; gi++) begin : g_word
    logic [31:0] word_reg;
    logic        hit;
    assign hit = ret_write && (ret_idx_i == lg_max_words_lp'(gi));

    always_ff @(posedge clk_i) begin
      if (reset_i || fwd_fire) begin
        word_reg     <= '0;
        mask_reg[gi] <= 1'b0;
      end else if (hit) begin
        word_reg     <= ret_data_i;
        mask_reg[gi] <= 1'b1;
      end
    end

    assign mem_rev_data_o[32*gi +: 32] = word_reg;
  end

  assign mem_rev_header_o = header_reg;
  assign err_o            = err_reg;

endmodule

// File: tb/tb_bp_hb_mem_rev_assembler.sv
// Directed and randomized bench for bp_hb_mem_rev_assembler against a word-array response model.
module tb_bp_hb_mem_rev_assembler;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [63:0]  fwd_header_i;
  logic [4:0]   fwd_words_i;
  logic         fwd_v_i;
  logic         fwd_ready_and_o;
  logic [31:0]  ret_data_i;
  logic [3:0]   ret_idx_i;
  logic         ret_v_i;
  logic         ret_ready_and_o;
  logic [63:0]  mem_rev_header_o;
  logic [511:0] mem_rev_data_o;
  logic         mem_rev_v_o;
  logic         mem_rev_ready_and_i;
  logic         err_o;

  always #5 clk = ~clk;

`ifdef BP_HB_REV_TIMEOUT_EN
  localparam int tb_timeout = 16;
`else
  localparam int tb_timeout = 1024;
`endif

  bp_hb_mem_rev_assembler #(
    .header_width_p(64),
    .max_words_p(16),
    .timeout_p(tb_timeout)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .fwd_header_i(fwd_header_i),
    .fwd_words_i(fwd_words_i),
    .fwd_v_i(fwd_v_i),
    .fwd_ready_and_o(fwd_ready_and_o),
    .ret_data_i(ret_data_i),
    .ret_idx_i(ret_idx_i),
    .ret_v_i(ret_v_i),
    .ret_ready_and_o(ret_ready_and_o),
    .mem_rev_header_o(mem_rev_header_o),
    .mem_rev_data_o(mem_rev_data_o),
    .mem_rev_v_o(mem_rev_v_o),
    .mem_rev_ready_and_i(mem_rev_ready_and_i),
    .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what the response must contain, derived from the returns sent so far.
  logic [63:0] m_hdr;
  int          m_count;
  logic [15:0] m_mask;
  logic [31:0] m_data [16];
  logic        m_err;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_flat();
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = m_mask[i] ? m_data[i] : 32'h0;
    return v;
  endfunction

  function automatic bit m_done();
    return $countones(m_mask) == m_count;
  endfunction

  task automatic start_txn(input logic [63:0] hdr, input int words);
    int guard = 0;
    while (fwd_ready_and_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("fwd_ready_before_hdr", fwd_ready_and_o, 1'b1);
    chk("rev_v_idle", mem_rev_v_o, 1'b0);
    fwd_header_i = hdr;
    fwd_words_i  = words[4:0];
    fwd_v_i      = 1'b1;
    @(negedge clk);
    fwd_v_i = 1'b0;
    m_hdr   = hdr;
    if (words == 0 || words > 16) begin
      m_count = 16;
      m_err   = 1'b1;
    end else begin
      m_count = words;
    end
    m_mask = '0;
    for (int i = 0; i < 16; i++) m_data[i] = '0;
    chk("ret_ready_collect", ret_ready_and_o, 1'b1);
    chk("fwd_ready_collect", fwd_ready_and_o, 1'b0);
    chk("err_after_hdr", err_o, m_err);
  endtask

  task automatic do_ret(input int idx, input logic [31:0] d);
    ret_v_i    = 1'b1;
    ret_idx_i  = idx[3:0];
    ret_data_i = d;
    chk("ret_ready", ret_ready_and_o, 1'b1);
    @(negedge clk);
    ret_v_i = 1'b0;
    if (idx >= m_count || m_mask[idx]) begin
      m_err = 1'b1;
    end else begin
      m_mask[idx] = 1'b1;
      m_data[idx] = d;
    end
    chk("err_after_ret", err_o, m_err);
    chk("rev_v_latency", mem_rev_v_o, m_done());
  endtask

  task automatic finish_response(input int hold);
    for (int h = 0; h < hold; h++) begin
      ret_v_i    = 1'b1;
      ret_idx_i  = 4'($urandom);
      ret_data_i = $urandom;
      chk("hold_v", mem_rev_v_o, 1'b1);
      chk("hold_ret_ready", ret_ready_and_o, 1'b0);
      chk("hold_data", mem_rev_data_o, exp_flat());
      @(negedge clk);
    end
    ret_v_i = 1'b0;
    chk("rev_v", mem_rev_v_o, 1'b1);
    chk("rev_header", mem_rev_header_o, m_hdr);
    for (int i = 0; i < 16; i++)
      chk($sformatf("word%0d", i), mem_rev_data_o[32*i +: 32], m_mask[i] ? m_data[i] : 32'h0);
    chk("rev_err", err_o, m_err);
    chk("send_fwd_ready", fwd_ready_and_o, 1'b0);
    chk("send_ret_ready", ret_ready_and_o, 1'b0);
    mem_rev_ready_and_i = 1'b1;
    @(negedge clk);
    mem_rev_ready_and_i = 1'b0;
    chk("rev_v_drop", mem_rev_v_o, 1'b0);
    chk("fwd_ready_after", fwd_ready_and_o, 1'b1);
    chk("ret_ready_after", ret_ready_and_o, 1'b0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    m_err  = 1'b0;
    m_mask = '0;
    m_hdr  = '0;
    chk("rst_fwd_ready", fwd_ready_and_o, 1'b1);
    chk("rst_ret_ready", ret_ready_and_o, 1'b0);
    chk("rst_rev_v", mem_rev_v_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_data", mem_rev_data_o, '0);
    chk("rst_header", mem_rev_header_o, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [16];
    int words, k, tmp, j;

    reset_i = 1'b0; fwd_header_i = '0; fwd_words_i = '0; fwd_v_i = 1'b0;
    ret_data_i = '0; ret_idx_i = '0; ret_v_i = 1'b0; mem_rev_ready_and_i = 1'b0;
    m_err = 1'b0; m_count = 0; m_mask = '0; m_hdr = '0;
    for (int i = 0; i < 16; i++) m_data[i] = '0;
    @(negedge clk);
    do_reset();

    // Two words returned out of order.
    start_txn(64'h1234_5678_9ABC_DEF0, 2);
    do_ret(1, 32'h0000_BBBB);
    do_ret(0, 32'h0000_AAAA);
    chk("pair_data", mem_rev_data_o[63:0], 64'h0000_BBBB_0000_AAAA);
    finish_response(0);

    // Full line in reverse order with a stalled consumer.
    start_txn(64'hCAFE_0000_0000_0016, 16);
    for (int i = 15; i >= 0; i--) do_ret(i, 32'hD000_0000 + i);
    finish_response(5);

    // Stray returns while idle are not accepted.
    ret_v_i = 1'b1; ret_idx_i = 4'd0; ret_data_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("idle_ret_ready", ret_ready_and_o, 1'b0);
      @(negedge clk);
    end
    ret_v_i = 1'b0;
    start_txn(64'h0000_0000_0000_0003, 3);
    do_ret(2, 32'h3333_0002);
    do_ret(0, 32'h3333_0000);
    do_ret(1, 32'h3333_0001);
    finish_response(1);

    // Duplicate index is dropped and flags an error.
    start_txn(64'h0000_0000_0000_0D0B, 4);
    do_ret(2, 32'h11);
    do_ret(2, 32'h22);
    do_ret(0, 32'h100);
    do_ret(1, 32'h101);
    do_ret(3, 32'h103);
    chk("dup_word2", mem_rev_data_o[95:64], 32'h11);
    finish_response(0);

    // Reset mid-collection discards partial data.
    do_reset();
    start_txn(64'h0000_0000_0000_0888, 8);
    do_ret(5, 32'h55);
    do_ret(1, 32'h11);
    do_ret(6, 32'h66);
    do_reset();
    start_txn(64'h0000_0000_0000_0001, 1);
    do_ret(0, 32'h0101_0101);
    finish_response(0);

    // Randomized transactions, including bad counts, duplicates and out-of-range indices.
    for (int t = 0; t < 25; t++) begin
      tmp = $urandom_range(0, 9);
      if (tmp == 0) words = 0;
      else if (tmp == 1) words = $urandom_range(17, 31);
      else words = $urandom_range(1, 16);
      start_txn({$urandom, $urandom}, words);
      for (int i = 0; i < 16; i++) order[i] = i;
      for (int i = m_count - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (k = 0; k < m_count; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          if (k > 0) do_ret(order[$urandom_range(0, k - 1)], $urandom);
          else if (m_count < 16) do_ret($urandom_range(m_count, 15), $urandom);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_ret(order[k], $urandom);
      end
      finish_response($urandom_range(0, 3));
    end

`ifdef BP_HB_REV_TIMEOUT_EN
    // Missing word: response forced out after the timeout with the gap zero-filled.
    do_reset();
    start_txn(64'h0000_0000_0000_7173, 4);
    do_ret(0, 32'hA0);
    do_ret(2, 32'hA2);
    do_ret(1, 32'hA1);
    repeat (12) @(negedge clk);
    chk("timeout_not_yet", mem_rev_v_o, 1'b0);
    chk("timeout_err_not_yet", err_o, 1'b0);
    @(negedge clk);
    chk("timeout_v", mem_rev_v_o, 1'b1);
    chk("timeout_err", err_o, 1'b1);
    m_err = 1'b1;
    chk("timeout_word3", mem_rev_data_o[127:96], 32'h0);
    finish_response(0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
